// File: rtl/dvsd_4bit_count_monitor.sv
// Protocol monitor for the 4-bit up/down counter output: infers direction, flags illegal steps,
// counts wraps and errors. Define COUNT_MON_HOLD_OK_EN to accept a repeated value as a legal hold.
module dvsd_4bit_count_monitor #(
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              valid,
  input  logic [3:0]        count_in,
  output logic              locked,
  output logic              dir,
  output logic              step_err,
  output logic              dir_chg,
  output logic              wrap,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  // state | meaning
  // EMPTY | no sample seen since reset/clr
  // ACQ   | have a reference sample, direction not yet established
  // UP    | locked, counter incrementing
  // DOWN  | locked, counter decrementing
  typedef enum logic [1:0] {EMPTY, ACQ, UP, DOWN} state_t;

  state_t            state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic [3:0]        delta;
  logic              is_up, is_dn, is_hold, illegal;
  logic              dir_d, step_err_d, dir_chg_d, wrap_d;
  logic [ERR_W-1:0]  err_cnt_d;
  logic [WRAP_W-1:0] wrap_cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      prev_q   <= 4'd0;
      locked   <= 1'b0;
      dir      <= 1'b0;
      step_err <= 1'b0;
      dir_chg  <= 1'b0;
      wrap     <= 1'b0;
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      locked   <= (state_d == UP) || (state_d == DOWN);
      dir      <= dir_d;
      step_err <= step_err_d;
      dir_chg  <= dir_chg_d;
      wrap     <= wrap_d;
      err_cnt  <= err_cnt_d;
      wrap_cnt <= wrap_cnt_d;
    end
  end

  always_comb begin
    delta = count_in - prev_q;
    is_up = (delta == 4'd1);
    is_dn = (delta == 4'd15);
`ifdef COUNT_MON_HOLD_OK_EN
    is_hold = (delta == 4'd0);
`else
    is_hold = 1'b0;
`endif
    illegal = !(is_up || is_dn || is_hold);
  end

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    dir_d      = dir;
    step_err_d = 1'b0;
    dir_chg_d  = 1'b0;
    wrap_d     = 1'b0;
    err_cnt_d  = err_cnt;
    wrap_cnt_d = wrap_cnt;

    if (clr) begin
      state_d    = EMPTY;
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
    end else if (valid) begin
      prev_d = count_in;
      case (state_q)
        EMPTY: state_d = ACQ;
        ACQ: begin
          if (is_up) begin
            state_d = UP;
            dir_d   = 1'b1;
          end else if (is_dn) begin
            state_d = DOWN;
            dir_d   = 1'b0;
          end else if (illegal) begin
            step_err_d = 1'b1;
          end
        end
        UP: begin
          if (is_dn) begin
            state_d   = DOWN;
            dir_d     = 1'b0;
            dir_chg_d = 1'b1;
          end else if (illegal) begin
            state_d    = ACQ;
            step_err_d = 1'b1;
          end
        end
        DOWN: begin
          if (is_up) begin
            state_d   = UP;
            dir_d     = 1'b1;
            dir_chg_d = 1'b1;
          end else if (illegal) begin
            state_d    = ACQ;
            step_err_d = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase

      if (state_q != EMPTY)
        wrap_d = (is_up && prev_q == 4'd15) || (is_dn && prev_q == 4'd0);

      // saturate rather than roll over so a long fault burst stays visible
      if (step_err_d && (err_cnt != '1))
        err_cnt_d = err_cnt + ERR_W'(1);
      if (wrap_d && (wrap_cnt != '1))
        wrap_cnt_d = wrap_cnt + WRAP_W'(1);
    end
  end

endmodule

// File: doc/dvsd_4bit_count_monitor.md
# dvsd_4bit_count_monitor

Registered protocol monitor for the 4-bit up/down binary counter output stream. It samples `count_in` on each `valid`, infers counting direction, flags illegal steps, and counts wrap-arounds and errors. It sits next to `dvsd_4bit_binary_counter` in the design and in its bench, and reads the `out` bus that the counter drives.

## Interface
- `ERR_W`, default 8: width of the saturating error counter.
- `WRAP_W`, default 8: width of the saturating wrap counter.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear: counters to 0, FSM to EMPTY.
- `valid`  in  1  `count_in` is a sample this cycle.
- `count_in`  in  4  observed counter value.
- `locked`  out  1  FSM is in UP or DOWN.
- `dir`  out  1  1 = counting up, 0 = counting down.
- `step_err`  out  1  one-cycle pulse: illegal step detected.
- `dir_chg`  out  1  one-cycle pulse: legal direction reversal.
- `wrap`  out  1  one-cycle pulse: 15→0 step (up) or 0→15 step (down).
- `err_cnt`  out  ERR_W  saturating count of `step_err` pulses.
- `wrap_cnt`  out  WRAP_W  saturating count of `wrap` pulses.

## Operation
- Holds `prev[3:0]`, the last accepted sample. Every accepted `valid` sample updates `prev`.
- For each sample, delta = (count_in − prev) mod 16, computed in 4 bits:
  - 1 = up step.
  - 15 = down step.
  - 0 = hold.
  - Any other value = illegal.
- FSM states EMPTY, ACQ, UP, DOWN:
  - EMPTY, on valid: store sample, go to ACQ. No checks are made.
  - ACQ, on valid: up → UP with `dir`=1; down → DOWN with `dir`=0; hold → stay in ACQ; illegal → `step_err`, stay in ACQ.
  - UP, on valid: up → stay; down → DOWN with `dir_chg`; hold → stay; illegal → `step_err`, go to ACQ.
  - DOWN is symmetric to UP.
- `wrap` pulses on an up step 15→0 or a down step 0→15, in ACQ, UP or DOWN.
- `dir` holds its last value while in ACQ or EMPTY.
- `err_cnt` and `wrap_cnt` increment with their pulses and saturate at all-ones; they never roll over.
- `valid`=0 means no state change and all pulses low.
- `clr` has priority over `valid`: the sample is discarded, counters go to 0, FSM goes to EMPTY, `dir` is kept, and no pulses are generated.

## Timing
- All outputs are registered. Latency is 1 cycle from the sampling edge: a sample accepted at edge N produces its pulse, state and counter update visible after edge N.
- Reset values: FSM=EMPTY, `prev`=0, `locked`=0, `dir`=0, `step_err`=0, `dir_chg`=0, `wrap`=0, `err_cnt`=0, `wrap_cnt`=0.
- Asserting `reset` low mid-stream clears all state immediately, without waiting for a clock edge. After release, the first valid sample is treated as EMPTY (no error).
- Back-to-back `valid` is supported at 1 sample per cycle with no throughput gaps.
- Simultaneous `step_err` and `wrap` cannot occur. `wrap` and `dir_chg` can pulse together, e.g. UP seeing 0→15.

## Configuration
- `COUNT_MON_HOLD_OK_EN`:
  - Defined: delta 0 is a legal hold, handled as above.
  - Undefined: delta 0 is illegal. It pulses `step_err`; UP and DOWN go to ACQ, ACQ stays in ACQ. This mode is for a free-running counter with no enable.

## Test plan
- Reset low, then release. Feed 3,4,5,6 on consecutive `valid` → `locked`=1 one cycle after the sample 4; `dir`=1; `err_cnt`=0.
- Up stream 14,15,0,1 → a single `wrap` pulse after sample 0; `wrap_cnt`=1.
- Stream 5,6,7,6,5 → `dir_chg` pulse after the second 6; `dir`=0; `locked` stays 1; then 5,4 keeps DOWN.
- In UP, feed 7 then 10 → `step_err` pulse; `locked`=0 (ACQ); `err_cnt`=1. Then 11 → UP again. Also drive 300 consecutive illegal samples → `err_cnt` saturates at 255.
- Feed 9,9 in UP → with `COUNT_MON_HOLD_OK_EN`: no error, stays UP. Without it: `step_err`, goes to ACQ.
- Assert `clr` together with `valid` (sample 4) while `err_cnt`=3 → counters 0, FSM EMPTY, sample discarded. Separately, assert `reset` mid-stream → all outputs 0 at once; the next sample gives no `step_err`.
